// File: rtl/xmodem_pkg.sv
// xmodem_pkg -- shared definitions for the XMODEM (checksum) block receiver.
//   SOH_BYTE/EOT_BYTE/ACK_BYTE/NAK_BYTE : protocol control bytes
//   BLK_BYTES_DEF                       : default payload bytes per block
//   xm_state_t                          : receiver FSM state encoding
package xmodem_pkg;

    localparam logic [7:0] SOH_BYTE = 8'h01;
    localparam logic [7:0] EOT_BYTE = 8'h04;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam int BLK_BYTES_DEF = 128;

    typedef enum logic [3:0] {
        IDLE,
        BLK,
        BLK_N,
        DATA,
        CSUM,
        DRAIN,
        ACK,
        NAK,
        DONE
    } xm_state_t;

endpackage

// File: rtl/xmodem_rx_blk_buf.sv
// xm_blk_buf -- single-port block buffer holding one XMODEM payload.
// A write and a read share the one address; the read data is registered,
// so rd_data shows mem[addr] one cycle after addr is presented.
//   clk     : clock
//   we      : write enable
//   addr    : byte index (write or read)
//   wdata   : byte to write
//   rd_data : registered read data
module xm_blk_buf #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rd_data <= mem[addr];
    end

endmodule

// File: rtl/xmodem_rx.sv
// xmodem_rx -- XMODEM (8-bit checksum) block receiver.
// Collects a block into a private buffer, and only once its checksum and
// sequence number are good streams the payload out with a running address,
// then answers ACK; bad or out-of-sequence blocks are answered with NAK.
// Ports:
//   clk, rst_b           : clock, synchronous active-low reset
//   rx_valid, rx_data    : byte strobe from the UART receiver
//   tx_valid, tx_data    : response byte (ACK/NAK) to the UART transmitter
//   tx_ready             : transmitter accepts the response
//   out_valid, out_data  : committed payload byte
//   out_addr             : running address of out_data (wraps at 2^ADDR_W)
//   out_ready            : downstream accepts the payload byte
//   done                 : EOT acknowledged, held until reset
//   err_cnt              : NAKs sent, saturating
// Build option: define XM_TIMEOUT_EN to NAK a block after TIMEOUT_CYC idle
// cycles inside the block; without it the receiver waits indefinitely.
//
// state | meaning
// IDLE  | waiting for SOH (start block) or EOT (end of transfer)
// BLK   | waiting for block number
// BLK_N | waiting for inverted block number
// DATA  | storing payload bytes and summing them
// CSUM  | waiting for checksum byte, then judging the block
// DRAIN | streaming the buffered payload to out_*
// ACK   | offering ACK until the transmitter takes it
// NAK   | offering NAK until the transmitter takes it
// DONE  | transfer finished, input ignored
module xmodem_rx
    import xmodem_pkg::*;
#(
    parameter int BLK_BYTES   = BLK_BYTES_DEF,
    parameter int ADDR_W      = 20,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              out_ready,
    output logic              done,
    output logic [7:0]        err_cnt
);

    // IW holds 0..BLK_BYTES, BW addresses the buffer
    localparam int IW = $clog2(BLK_BYTES + 1);
    localparam int BW = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(BLK_BYTES - 1);
    localparam logic [IW-1:0] IDX_FULL = IW'(BLK_BYTES);

    xm_state_t     state;
    logic [7:0]    blk_num;
    logic [7:0]    expected;
    logic [7:0]    sum;
    logic          hdr_bad;
    logic          eot;
    logic [IW-1:0] idx;
    logic [7:0]    first_byte;

    logic          buf_we;
    logic [BW-1:0] buf_addr;
    logic [7:0]    rd_data;
    logic          tmo_hit;

    // Byte 0 is kept in first_byte so out_data can load it on the checksum
    // cycle; meanwhile the buffer is already reading byte 1. In DRAIN the
    // address runs one ahead on an accept so rd_data always holds byte idx.
    always_comb begin
        buf_we   = 1'b0;
        buf_addr = BW'(1);
        case (state)
            DATA: begin
                buf_we   = rx_valid;
                buf_addr = idx[BW-1:0];
            end
            DRAIN: begin
                buf_addr = out_ready ? BW'(idx + IW'(1)) : idx[BW-1:0];
            end
            default: buf_addr = BW'(1);
        endcase
    end

    xm_blk_buf #(
        .DEPTH (BLK_BYTES),
        .AW    (BW)
    ) u_buf (
        .clk     (clk),
        .we      (buf_we),
        .addr    (buf_addr),
        .wdata   (rx_data),
        .rd_data (rd_data)
    );

`ifdef XM_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        tmo_run;

    assign tmo_run = (state == BLK) || (state == BLK_N) ||
                     (state == DATA) || (state == CSUM);
    assign tmo_hit = tmo_run && !rx_valid &&
                     (tmo_cnt == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_b || rx_valid || !tmo_run) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    logic unused_timeout;
    assign tmo_hit        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_addr   <= '0;
            done       <= 1'b0;
            err_cnt    <= 8'h00;
            expected   <= 8'h01;
            sum        <= 8'h00;
            blk_num    <= 8'h00;
            hdr_bad    <= 1'b0;
            eot        <= 1'b0;
            idx        <= '0;
            first_byte <= 8'h00;
        end else if (tmo_hit) begin
            state    <= NAK;
            tx_valid <= 1'b1;
            tx_data  <= NAK_BYTE;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == SOH_BYTE) begin
                            state   <= BLK;
                            sum     <= 8'h00;
                            idx     <= '0;
                            hdr_bad <= 1'b0;
                            eot     <= 1'b0;
                        end else if (rx_data == EOT_BYTE) begin
                            state    <= ACK;
                            eot      <= 1'b1;
                            tx_valid <= 1'b1;
                            tx_data  <= ACK_BYTE;
                        end
                    end
                end
                BLK: begin
                    if (rx_valid) begin
                        blk_num <= rx_data;
                        state   <= BLK_N;
                    end
                end
                BLK_N: begin
                    if (rx_valid) begin
                        hdr_bad <= (rx_data != ~blk_num);
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        sum <= sum + rx_data;
                        if (idx == '0) begin
                            first_byte <= rx_data;
                        end
                        idx <= idx + IW'(1);
                        if (idx == IDX_LAST) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (rx_valid) begin
                        if (hdr_bad || (sum != rx_data)) begin
                            state    <= NAK;
                            tx_valid <= 1'b1;
                            tx_data  <= NAK_BYTE;
                        end else if (blk_num == expected) begin
                            state     <= DRAIN;
                            out_valid <= 1'b1;
                            out_data  <= first_byte;
                            idx       <= IW'(1);
                        end else if (blk_num == expected - 8'd1) begin
                            // retransmission of a block already committed
                            state    <= ACK;
                            tx_valid <= 1'b1;
                            tx_data  <= ACK_BYTE;
                        end else begin
                            state    <= NAK;
                            tx_valid <= 1'b1;
                            tx_data  <= NAK_BYTE;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        out_addr <= out_addr + ADDR_W'(1);
                        if (idx == IDX_FULL) begin
                            out_valid <= 1'b0;
                            expected  <= expected + 8'd1;
                            state     <= ACK;
                            tx_valid  <= 1'b1;
                            tx_data   <= ACK_BYTE;
                        end else begin
                            out_data <= rd_data;
                            idx      <= idx + IW'(1);
                        end
                    end
                end
                ACK: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (eot) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                NAK: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xmodem_rx.sv
module tb_xmodem_rx;

    localparam int NB     = 128;
    localparam int AW     = 8;
    localparam int TMO    = 400;
    localparam logic [7:0] C_SOH = 8'h01;
    localparam logic [7:0] C_EOT = 8'h04;
    localparam int C_ACK = 6;
    localparam int C_NAK = 21;

    logic          clk;
    logic          rst_b;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [AW-1:0] out_addr;
    logic          out_ready;
    logic          done;
    logic [7:0]    err_cnt;

    xmodem_rx #(
        .BLK_BYTES   (NB),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_ready (out_ready),
        .done      (done),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // observation state
    int cap_addr[$];
    int cap_data[$];
    int txq[$];
    int ready_mode = 0;   // 0: always ready, 1: random, 2: out_ready held low
    int in_hdr = 0;
    int early = 0;
    int overlap = 0;

    // reference model of the protocol
    int m_exp  = 1;
    int m_addr = 0;
    int m_err  = 0;

    typedef struct {
        int blk;
        int hdr_bad;
        int sum_delta;
        int mode;
        int inject;
        int exp_resp;
        int exp_commit;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // samples handshakes that the coming edge will complete, then steps
    task automatic tick();
        if (ready_mode == 1) begin
            out_ready = 1'($urandom_range(0, 1));
            tx_ready  = 1'($urandom_range(0, 1));
        end else if (ready_mode == 2) begin
            out_ready = 1'b0;
            tx_ready  = 1'b1;
        end else begin
            out_ready = 1'b1;
            tx_ready  = 1'b1;
        end
        if (out_valid && out_ready) begin
            cap_addr.push_back(int'(out_addr));
            cap_data.push_back(int'(out_data));
        end
        if (tx_valid && tx_ready) txq.push_back(int'(tx_data));
        if (tx_valid && out_valid) overlap++;
        if (in_hdr != 0 && out_valid) early++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_tx(output int resp);
        int n;
        n = 0;
        while (txq.size() == 0 && n < 5000) begin
            tick();
            n++;
        end
        resp = (txq.size() > 0) ? txq[0] : -1;
    endtask

    // exp_resp/exp_commit < 0 means: take the model's prediction
    task automatic send_block(input int blk, input int hdr_bad, input int sum_delta,
                              input int mode, input int inject,
                              input int exp_resp, input int exp_commit);
        logic [7:0] pay [NB];
        logic [7:0] cs;
        int s, resp_m, commit_m, chk_resp, chk_commit, resp, errs;
        s = 0;
        for (int i = 0; i < NB; i++) begin
            pay[i] = 8'($urandom_range(0, 255));
            s += int'(pay[i]);
        end
        cs = 8'((s + sum_delta) & 255);

        if (hdr_bad != 0 || sum_delta != 0) begin
            resp_m = C_NAK; commit_m = 0;
        end else if (blk == m_exp) begin
            resp_m = C_ACK; commit_m = 1;
        end else if (blk == (m_exp + 255) % 256) begin
            resp_m = C_ACK; commit_m = 0;
        end else begin
            resp_m = C_NAK; commit_m = 0;
        end
        chk_resp   = (exp_resp < 0) ? resp_m : exp_resp;
        chk_commit = (exp_commit < 0) ? commit_m : exp_commit;

        cap_addr.delete();
        cap_data.delete();
        txq.delete();
        early = 0;
        overlap = 0;
        ready_mode = mode;
        in_hdr = 1;

        send_byte(C_SOH, $urandom_range(0, 2));
        send_byte(8'(blk), $urandom_range(0, 2));
        send_byte(~8'(blk) ^ ((hdr_bad != 0) ? 8'h10 : 8'h00), $urandom_range(0, 2));
        for (int i = 0; i < NB; i++) send_byte(pay[i], (i == NB - 1) ? 0 : $urandom_range(0, 2));
        send_byte(cs, 0);
        in_hdr = 0;

        if (chk_commit != 0) begin
            check("lat_out_valid", 32'(out_valid), 1);
            check("first_addr", 32'(out_addr), m_addr);
            check("first_data", 32'(out_data), 32'(pay[0]));
        end else begin
            check("lat_tx_valid", 32'(tx_valid), 1);
            check("lat_tx_data", 32'(tx_data), chk_resp);
        end

        if (inject != 0) begin
            ready_mode = 2;
            send_byte(C_SOH, 1);
            send_byte(8'(blk + 1), 1);
            ready_mode = mode;
        end

        wait_tx(resp);
        check("tx_resp", resp, chk_resp);
        check("out_count", cap_addr.size(), (chk_commit != 0) ? NB : 0);
        if (chk_commit != 0 && cap_addr.size() == NB) begin
            errs = 0;
            for (int i = 0; i < NB; i++) begin
                if (cap_addr[i] != (m_addr + i) % 256 || cap_data[i] != int'(pay[i])) begin
                    if (errs == 0)
                        $display("out byte %0d: addr %0d data %0h, want addr %0d data %0h",
                                 i, cap_addr[i], cap_data[i], (m_addr + i) % 256, pay[i]);
                    errs++;
                end
            end
            check("out_order", errs, 0);
        end
        check("early_out", early, 0);
        check("tx_during_drain", overlap, 0);

        if (commit_m != 0) begin
            m_addr = (m_addr + NB) % 256;
            m_exp  = (m_exp + 1) % 256;
        end
        if (resp_m == C_NAK && m_err < 255) m_err++;

        ready_mode = 0;
        repeat (3) tick();
        check("err_cnt", 32'(err_cnt), m_err);
        check("out_addr", 32'(out_addr), m_addr);
    endtask

    task automatic check_reset_vals();
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
    endtask

    initial begin
        int resp, r, b;
        rst_b     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        out_ready = 1'b1;
        tx_ready  = 1'b1;

        // blk, hdr_bad, sum_delta, mode, inject, exp_resp, exp_commit
        vecs[0] = '{1, 0, -1, 0, 0, C_NAK, 0};  // bad checksum
        vecs[1] = '{1, 0,  0, 0, 0, C_ACK, 1};  // resend, commits at 0
        vecs[2] = '{1, 0,  0, 0, 0, C_ACK, 0};  // duplicate
        vecs[3] = '{3, 0,  0, 0, 0, C_NAK, 0};  // out of sequence
        vecs[4] = '{2, 1,  0, 0, 0, C_NAK, 0};  // bad inverted number
        vecs[5] = '{2, 0,  0, 1, 0, C_ACK, 1};  // random back-pressure
        vecs[6] = '{3, 0,  0, 0, 1, C_ACK, 1};  // rx during DRAIN dropped
        vecs[7] = '{4, 0,  0, 1, 0, C_ACK, 1};

        repeat (3) tick();
        check_reset_vals();
        rst_b = 1'b1;
        tick();

        for (int v = 0; v < 8; v++)
            send_block(vecs[v].blk, vecs[v].hdr_bad, vecs[v].sum_delta, vecs[v].mode,
                       vecs[v].inject, vecs[v].exp_resp, vecs[v].exp_commit);

        for (int k = 0; k < 8; k++) begin
            r = $urandom_range(0, 3);
            b = (r == 2) ? (m_exp + 255) % 256 : (r == 3) ? (m_exp + 1) % 256 : m_exp;
            send_block(b, ($urandom_range(0, 7) == 0) ? 1 : 0,
                       ($urandom_range(0, 7) == 0) ? 1 : 0,
                       $urandom_range(0, 1), 0, -1, -1);
        end

        // end of transfer
        txq.delete();
        cap_addr.delete();
        send_byte(C_EOT, 0);
        check("eot_lat_tx_valid", 32'(tx_valid), 1);
        wait_tx(resp);
        check("eot_resp", resp, C_ACK);
        tick();
        check("done_set", 32'(done), 1);
        txq.delete();
        send_byte(C_SOH, 1);
        send_byte(8'h05, 1);
        send_byte(8'hFA, 1);
        for (int i = 0; i < 10; i++) send_byte(8'(i), 0);
        repeat (20) tick();
        check("done_ignores_tx", txq.size(), 0);
        check("done_ignores_out", cap_addr.size(), 0);
        check("done_held", 32'(done), 1);

        // reset clears everything
        rst_b = 1'b0;
        repeat (2) tick();
        check_reset_vals();
        rst_b = 1'b1;
        tick();
        m_exp = 1; m_addr = 0; m_err = 0;

        // reset in the middle of a block
        send_byte(C_SOH, 1);
        send_byte(8'h01, 1);
        send_byte(8'hFE, 1);
        for (int i = 0; i < 60; i++) send_byte(8'($urandom_range(0, 255)), 1);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        send_block(1, 0, 0, 0, 0, C_ACK, 1);

`ifdef XM_TIMEOUT_EN
        begin
            int n;
            txq.delete();
            send_byte(C_SOH, 0);
            send_byte(8'(m_exp), 0);
            n = 0;
            while (!tx_valid && n < TMO + 200) begin
                tick();
                n++;
            end
            check("tmo_cycles", n, TMO);
            check("tmo_tx_data", 32'(tx_data), C_NAK);
            wait_tx(resp);
            check("tmo_resp", resp, C_NAK);
            m_err++;
            repeat (2) tick();
            check("tmo_err_cnt", 32'(err_cnt), m_err);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xmodem_rx.md
XMODEM_RX -- requirements
Module: xmodem_rx

Interface
REQ-001 Parameter BLK_BYTES, default 128, payload bytes per XMODEM block.
REQ-002 Parameter ADDR_W, default 20, width of committed-byte address.
REQ-003 Parameter TIMEOUT_CYC, default 50_000_000, idle cycles before timeout NAK (used only when XM_TIMEOUT_EN is defined).
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 rst_b  input  1  synchronous, active-low reset.
REQ-006 rx_valid  input  1  one-cycle pulse, byte received by the UART receiver.
REQ-007 rx_data  input  8  received byte, valid with rx_valid.
REQ-008 tx_valid  output  1  request to transmit one response byte.
REQ-009 tx_data  output  8  response byte: ACK 8'h06 or NAK 8'h15.
REQ-010 tx_ready  input  1  UART transmitter accepts tx_data when tx_valid and tx_ready are both high.
REQ-011 out_valid  output  1  committed payload byte available.
REQ-012 out_data  output  8  committed payload byte.
REQ-013 out_addr  output  ADDR_W  running byte address of out_data, starting at 0.
REQ-014 out_ready  input  1  downstream (SRAM/scene loader) accepts the byte.
REQ-015 done  output  1  high after EOT has been ACKed; held until reset.
REQ-016 err_cnt  output  8  count of NAKs sent, saturating at 8'hFF.

Function
REQ-017 States: IDLE, BLK, BLK_N, DATA, CSUM, DRAIN, ACK, NAK, DONE.
REQ-018 IDLE: SOH 8'h01 -> BLK; EOT 8'h04 -> ACK with eot flag set; any other byte is ignored.
REQ-019 BLK latches the block number; BLK_N checks that the byte equals the bitwise inverse of the block number.
REQ-020 DATA writes BLK_BYTES bytes into the block buffer at index 0..BLK_BYTES-1 and accumulates an 8-bit modulo-256 sum.
REQ-021 CSUM: header bad, or sum != received byte -> NAK.
REQ-022 CSUM, good and blk == expected -> DRAIN.
REQ-023 CSUM, good and blk == expected-1 (mod 256; duplicate block) -> ACK with no commit.
REQ-024 CSUM, good and any other blk -> NAK.
REQ-025 expected resets to 8'h01 and increments mod 256 (8'hFF wraps to 8'h00) on each committed block.
REQ-026 DRAIN presents buffer bytes in order, one per out_valid&&out_ready cycle, with out_addr incrementing per accepted byte; after the last accept -> ACK.
REQ-027 out_addr wraps at 2^ADDR_W without error.
REQ-028 No byte is visible on out_* before its block's checksum has passed.
REQ-029 ACK/NAK states hold tx_valid high with the constant byte until tx_ready.
REQ-030 On accept: ACK -> IDLE, or DONE if eot; NAK -> IDLE and increments err_cnt.
REQ-031 rx_valid pulses arriving in DRAIN, ACK or NAK are dropped, and the block is NAKed if it then proves incomplete.
REQ-032 DONE ignores all rx input; done stays 1.
REQ-033 Latency: tx_valid rises the cycle after the checksum byte for NAK or duplicate-ACK; out_valid rises the cycle after the checksum byte for a good block.

Reset
REQ-034 While rst_b==0 at posedge: state=IDLE, tx_valid=0, tx_data=8'h00, out_valid=0, out_data=8'h00, out_addr=0, done=0, err_cnt=0, expected=8'h01, sum=0.
REQ-035 Reset mid-block or mid-drain discards the partial block; buffer contents need not be cleared.

Configuration
REQ-036 Macro XM_TIMEOUT_EN.
REQ-037 With XM_TIMEOUT_EN defined, a counter cleared on every rx_valid, and counting in BLK, BLK_N, DATA and CSUM, forces NAK on reaching TIMEOUT_CYC.
REQ-038 Without XM_TIMEOUT_EN, no timeout counter exists and the receiver waits indefinitely.

Structure
REQ-039 Package xmodem_pkg holds: SOH/EOT/ACK/NAK constants, the state enum, and the default BLK_BYTES.
REQ-040 Sub-module xm_blk_buf: BLK_BYTES x 8 single-port buffer with registered read, one-cycle read latency, absorbed by a DRAIN prefetch register.

Verification
REQ-041 Good block 1 (128 random bytes, correct sum) -> 128 out bytes at addr 0..127 in order, then tx 8'h06.
REQ-042 Block with checksum sum-1 -> tx 8'h15, no out_valid, err_cnt=1; the resend then commits at addr 0..127.
REQ-043 Block 1 sent twice -> second receives 8'h06, no out bytes, out_addr stays 128.
REQ-044 out_ready toggled 50% during DRAIN -> data order preserved, ACK only after the 128th accept.
REQ-045 Good block, then EOT -> tx 8'h06, done=1; further SOH is ignored.
REQ-046 rst_b pulsed low at DATA byte 60, then a full good block -> commit at addr 0, expected block=1; with XM_TIMEOUT_EN, silence after BLK -> NAK at TIMEOUT_CYC.
